// File: rtl/async_fifo.sv
// async_fifo: single-clock FIFO, DEPTH = 2**ADDR_WIDTH, wrap-bit pointers.
// Define ASYNC_FIFO_ERR_FLAGS_EN for sticky overflow/underflow outputs.
module async_fifo #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  w_clk,
  input  logic                  w_rst_n,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  full,
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow
`else
  output logic                  empty
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wptr;
  logic [ADDR_WIDTH:0]   rptr;
  logic                  w_acc;
  logic                  r_acc;

  // flags come straight from the registered pointers
  always_comb begin
    empty = (wptr == rptr);
    full  = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH])
         && (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
    w_acc = w_rst_n && w_en && !full;
    r_acc = w_rst_n && r_en && !empty;
  end

  // storage; no reset needed since empty gates every read
  always_ff @(posedge w_clk) begin
    if (w_acc)
      mem[wptr[ADDR_WIDTH-1:0]] <= w_data;
  end

  // pointers and registered read data
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      wptr   <= '0;
      rptr   <= '0;
      r_data <= '0;
    end else begin
      if (w_acc)
        wptr <= wptr + PTR_ONE;
      if (r_acc) begin
        r_data <= mem[rptr[ADDR_WIDTH-1:0]];
        rptr   <= rptr + PTR_ONE;
      end
    end
  end

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  // sticky error flags, cleared only by reset
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_en && full)
        overflow <= 1'b1;
      if (r_en && empty)
        underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_async_fifo.sv
// tb_async_fifo: directed stimulus, queue scoreboard, per-cycle monitor.
// Define ASYNC_FIFO_ERR_FLAGS_EN to also check overflow/underflow.
module tb_async_fifo;

  logic       w_clk = 1'b0;
  logic       w_rst_n = 1'b0;
  logic       w_en = 1'b0;
  logic [3:0] w_data = '0;
  logic       r_en = 1'b0;
  logic [3:0] r_data;
  logic       full;
  logic       empty;
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  logic       overflow;
  logic       underflow;
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
`endif

  int total = 0;
  int bad = 0;

  logic [3:0] mq[$];
  logic [3:0] sb[$];
  logic [3:0] hold = '0;

  async_fifo #(.DATA_WIDTH(4), .ADDR_WIDTH(3)) dut (
    .w_clk    (w_clk),
    .w_rst_n  (w_rst_n),
    .w_en     (w_en),
    .w_data   (w_data),
    .r_en     (r_en),
    .r_data   (r_data),
    .full     (full),
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    .empty    (empty),
    .overflow (overflow),
    .underflow(underflow)
`else
    .empty    (empty)
`endif
  );

  always #5 w_clk = ~w_clk;

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // one clock of stimulus plus the reference model update at the edge
  task automatic cyc(logic rst, logic we, logic [3:0] wd, logic re);
    int c;
    @(negedge w_clk);
    w_rst_n = rst;
    w_en    = we;
    w_data  = wd;
    r_en    = re;
    @(posedge w_clk);
    c = mq.size();
    if (!rst) begin
      mq.delete();
      sb.push_back(4'h0);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
      m_ovf = 1'b0;
      m_unf = 1'b0;
`endif
    end else begin
      if (re && c > 0)
        sb.push_back(mq.pop_front());
      if (we && c < 8)
        mq.push_back(wd);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
      if (we && c == 8) m_ovf = 1'b1;
      if (re && c == 0) m_unf = 1'b1;
`endif
    end
  endtask

  // monitor: pops the expected read data and checks flags every cycle
  always @(posedge w_clk) begin
    #1;
    if (sb.size() > 0)
      hold = sb.pop_front();
    chk("r_data", {4'h0, r_data}, {4'h0, hold});
    chk("empty", {7'h0, empty}, {7'h0, mq.size() == 0});
    chk("full", {7'h0, full}, {7'h0, mq.size() == 8});
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    chk("overflow", {7'h0, overflow}, {7'h0, m_ovf});
    chk("underflow", {7'h0, underflow}, {7'h0, m_unf});
`endif
  end

  initial begin
    // reset held with a pending write
    cyc(1'b0, 1'b1, 4'hA, 1'b0);
    cyc(1'b0, 1'b1, 4'hA, 1'b0);
    // single write then read
    cyc(1'b1, 1'b1, 4'h5, 1'b0);
    cyc(1'b1, 1'b0, 4'h0, 1'b1);
    cyc(1'b1, 1'b0, 4'h0, 1'b0);
    // fill, overflow attempt, drain in order
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 1'b1, 4'(i), 1'b0);
    cyc(1'b1, 1'b1, 4'h9, 1'b0);
    // full with simultaneous read: write must be ignored
    cyc(1'b1, 1'b1, 4'hE, 1'b1);
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 1'b0, 4'h0, 1'b1);
    // underflow: empty read, then simultaneous read/write on empty
    cyc(1'b1, 1'b0, 4'h0, 1'b1);
    cyc(1'b1, 1'b1, 4'hC, 1'b1);
    cyc(1'b1, 1'b0, 4'h0, 1'b1);
    cyc(1'b1, 1'b0, 4'h0, 1'b0);
    // simultaneous traffic across pointer wrap
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b1, 4'(10 + i), 1'b0);
    for (int i = 0; i < 20; i++)
      cyc(1'b1, 1'b1, 4'(13 + i), 1'b1);
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 1'b0, 4'h0, 1'b1);
    // reset mid-operation discards contents
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 1'b1, 4'(i + 3), 1'b0);
    cyc(1'b0, 1'b1, 4'hF, 1'b1);
    cyc(1'b1, 1'b0, 4'h0, 1'b1);
    cyc(1'b1, 1'b1, 4'h6, 1'b0);
    cyc(1'b1, 1'b0, 4'h0, 1'b1);
    // random writes, random reads, drain
    for (int i = 0; i < 50; i++)
      cyc(1'b1, 1'($urandom_range(0, 1)),
          4'($urandom_range(0, 15)), 1'b0);
    for (int i = 0; i < 60; i++)
      cyc(1'b1, 1'b0, 4'h0, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 1'b0, 4'h0, 1'b1);
    cyc(1'b1, 1'b0, 4'h0, 1'b0);
    @(negedge w_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
